pcm_frame_serializer: RTL and testbench
=======================================

PCM_FRAME_SERIALIZER -- requirements
Module: pcm_frame_serializer

Interface
REQ-001 Parameter NCH, default 20, number of microphone channels fed by the per-channel F_FIR outputs.
REQ-002 Parameter DW, default 16, sample width in bits.
REQ-003 Parameter CW, default $clog2(NCH), channel index width.
REQ-004 Port clk  input  1  system clock; all logic is on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port sample_stb  input  1  one-cycle pulse: ch_data holds a new valid sample set for all channels.
REQ-007 Port ch_data  input  NCH*DW  flattened samples; channel k occupies bits [k*DW +: DW], two's complement.
REQ-008 Port m_data  output  DW  serialized sample.
REQ-009 Port m_chan  output  CW  channel index of m_data.
REQ-010 Port m_valid  output  1  m_data, m_chan, m_first and m_last are valid.
REQ-011 Port m_ready  input  1  downstream accepts; a handshake is m_valid && m_ready in the same cycle.
REQ-012 Port m_first  output  1  high with channel 0 of a frame.
REQ-013 Port m_last  output  1  high with channel NCH-1 of a frame.
REQ-014 Port overflow  output  1  sticky; a sample set was dropped.
REQ-015 Port clr_ovf  input  1  clears overflow.
REQ-016 Port frame_cnt  output  16  count of completed frames.

Function
REQ-017 The block SHALL hold one active buffer and one pending buffer, each NCH*DW bits, plus a pending-full flag.
REQ-018 State machine: IDLE (m_valid=0) and SEND (m_valid=1); the block SHALL have no other states.
REQ-019 In IDLE, a sample_stb at cycle N SHALL capture ch_data into the active buffer and enter SEND, with m_valid=1, m_chan=0 and m_data=channel 0 of the cycle-N data at cycle N+1. Latency is 1 cycle.
REQ-020 In SEND, while m_valid && !m_ready, m_data, m_chan, m_first and m_last SHALL hold stable.
REQ-021 Each handshake SHALL advance m_chan by 1. m_data SHALL be the active-buffer slot at index m_chan.
REQ-022 m_first SHALL equal (m_chan==0). m_last SHALL equal (m_chan==NCH-1). Both SHALL be 0 when m_valid=0.
REQ-023 A handshake with m_last=1 completes the frame:
- frame_cnt increments by 1 and wraps from 65535 to 0.
- m_chan returns to 0.
REQ-024 On frame completion with pending full:
- the pending buffer moves to the active buffer;
- pending-full clears;
- SEND continues with channel 0 on the next cycle, with no idle cycle.
REQ-025 On frame completion with pending empty and no sample_stb in that cycle, the block SHALL go to IDLE.
REQ-026 sample_stb in the same cycle as a completing handshake, with pending empty, SHALL load ch_data directly into the active buffer and continue SEND at channel 0 next cycle.
REQ-027 sample_stb in the same cycle as a completing handshake, with pending full: the pending buffer moves to active, and ch_data is captured into pending, which stays full.
REQ-028 sample_stb during SEND, not completing, with pending empty, SHALL capture ch_data into pending and set pending-full.
REQ-029 sample_stb during SEND with pending full and no completing handshake SHALL discard ch_data and set overflow. Pending contents SHALL remain unchanged.
REQ-030 overflow SHALL stay set until clr_ovf=1. If set and clear occur in the same cycle, set wins.
REQ-031 Samples SHALL pass bit-exact: no rounding, saturation or sign change.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL go to IDLE with pending-full=0 and the following outputs zero: m_valid, m_first, m_last, m_chan, m_data, overflow and frame_cnt.
REQ-033 Reset mid-frame SHALL abort the frame, drive m_valid=0 on the next cycle, and leave frame_cnt at 0. sample_stb during reset SHALL be ignored.
REQ-034 Buffer data contents need not reset. Only the control state and the listed outputs are reset.

Verification
REQ-035 NCH=20, m_ready=1: ch_data channel k = 16'h0100+k, stb at cycle 10 -> m_valid cycles 11..30; m_data = 16'h0100..16'h0113; m_first at 11; m_last at 30; frame_cnt=1 at 31; m_valid=0 at 31.
REQ-036 NCH=4, m_ready toggles 1,0,1,0, channel values 16'h8000,16'h7FFF,16'hFFFF,16'h0001 -> values and channel order exact; outputs stable during every m_ready=0 cycle.
REQ-037 NCH=4, m_ready=0: three strobes -> frame A active, frame B pending, third dropped, overflow=1. Then m_ready=1 -> A then B back-to-back with no gap, then IDLE; frame_cnt=2.
REQ-038 Strobe coincident with the last handshake, pending empty -> next cycle m_chan=0, m_first=1 with new data, no idle cycle. Strobe and clr_ovf coincident with a drop -> overflow remains 1.
REQ-039 rst=1 asserted at channel 2 of a frame -> the next cycle m_valid=0, frame_cnt=0, overflow=0. The next strobe starts at channel 0.
REQ-040 frame_cnt preloaded by forcing 65535 completed frames (NCH=1) -> the next completion wraps frame_cnt to 0.

Source files
------------

// File: rtl/pcm_frame_serializer.sv
// rtl/pcm_frame_serializer.sv - double-buffered serializer turning per-channel PCM sample sets into a channel stream
// One active frame is being sent while at most one further sample set waits in the pending buffer.
module pcm_frame_serializer #(
    parameter int NCH = 20,
    parameter int DW  = 16,
    parameter int CW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_stb,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [DW-1:0]     m_data,
    output logic [CW-1:0]     m_chan,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              m_last,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [15:0]       frame_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    state_t            state_q, state_d;
    logic [NCH*DW-1:0] act_q, act_d;
    logic [NCH*DW-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              hs;
    logic              at_last;
    logic              done;
    logic              ovf_set;

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        chan_d      = chan_q;
        fcnt_d      = fcnt_q;
        ovf_set     = 1'b0;
        hs          = (state_q == SEND) && m_ready;
        at_last     = (chan_q == LAST_CH);
        done        = hs && at_last;

        case (state_q)
            IDLE: begin
                if (sample_stb) begin
                    act_d   = ch_data;
                    chan_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    chan_d = at_last ? '0 : chan_q + CW'(1);
                end
                if (done) begin
                    fcnt_d = fcnt_q + 16'd1;
                    // The pending set always goes out before a strobe that lands on the completing cycle.
                    if (pend_full_q) begin
                        act_d = pend_q;
                        if (sample_stb) begin
                            pend_d = ch_data;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (sample_stb) begin
                        act_d = ch_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (sample_stb) begin
                    if (!pend_full_q) begin
                        pend_d      = ch_data;
                        pend_full_d = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ovf_d = clr_ovf ? 1'b0 : ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_full_q <= 1'b0;
            chan_q      <= '0;
            ovf_q       <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            chan_q      <= chan_d;
            ovf_q       <= ovf_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // Sample buffers carry no reset; their contents are only observed while in SEND.
    always_ff @(posedge clk) begin
        act_q  <= act_d;
        pend_q <= pend_d;
    end

    assign m_valid   = (state_q == SEND);
    assign m_chan    = chan_q;
    assign m_data    = m_valid ? act_q[chan_q*DW +: DW] : '0;
    assign m_first   = m_valid && (chan_q == '0);
    assign m_last    = m_valid && at_last;
    assign overflow  = ovf_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_pcm_frame_serializer.sv
// tb/tb_pcm_frame_serializer.sv - self-checking bench for pcm_frame_serializer
module tb_pcm_frame_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_stb = 0, a_ready = 1, a_clr = 0;
    logic [319:0]  a_data = '0;
    logic [15:0]   a_mdata, a_fc;
    logic [4:0]    a_chan;
    logic          a_valid, a_first, a_last, a_ovf;

    logic          b_stb = 0, b_ready = 0, b_clr = 0;
    logic [63:0]   b_data = '0;
    logic [15:0]   b_mdata, b_fc;
    logic [1:0]    b_chan;
    logic          b_valid, b_first, b_last, b_ovf;

    logic          c_stb = 0, c_ready = 0, c_clr = 0;
    logic [15:0]   c_data = '0;
    logic [15:0]   c_mdata, c_fc;
    logic [0:0]    c_chan;
    logic          c_valid, c_first, c_last, c_ovf;

    pcm_frame_serializer #(.NCH(20), .DW(16)) u_a (
        .clk(clk), .rst(rst), .sample_stb(a_stb), .ch_data(a_data), .m_data(a_mdata),
        .m_chan(a_chan), .m_valid(a_valid), .m_ready(a_ready), .m_first(a_first),
        .m_last(a_last), .overflow(a_ovf), .clr_ovf(a_clr), .frame_cnt(a_fc));

    pcm_frame_serializer #(.NCH(4), .DW(16)) u_b (
        .clk(clk), .rst(rst), .sample_stb(b_stb), .ch_data(b_data), .m_data(b_mdata),
        .m_chan(b_chan), .m_valid(b_valid), .m_ready(b_ready), .m_first(b_first),
        .m_last(b_last), .overflow(b_ovf), .clr_ovf(b_clr), .frame_cnt(b_fc));

    pcm_frame_serializer #(.NCH(1), .DW(16), .CW(1)) u_c (
        .clk(clk), .rst(rst), .sample_stb(c_stb), .ch_data(c_data), .m_data(c_mdata),
        .m_chan(c_chan), .m_valid(c_valid), .m_ready(c_ready), .m_first(c_first),
        .m_last(c_last), .overflow(c_ovf), .clr_ovf(c_clr), .frame_cnt(c_fc));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for u_b: the block behaves as a two-deep FIFO of whole frames
    logic [63:0] mq[$];
    int          mchan = 0;
    bit          movf = 0;
    logic [15:0] mfc = 0;
    bit          mdrop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mchan = 0;
            movf  = 0;
            mfc   = 0;
        end else begin
            mdrop = 0;
            if (mq.size() > 0 && b_ready) begin
                if (mchan == 3) begin
                    void'(mq.pop_front());
                    mchan = 0;
                    mfc   = mfc + 16'd1;
                end else begin
                    mchan++;
                end
            end
            if (b_stb) begin
                if (mq.size() < 2) mq.push_back(b_data);
                else mdrop = 1;
            end
            if (b_clr) movf = 0;
            if (mdrop) movf = 1;
        end
    end

    logic [63:0] cur;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("b_valid", b_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                cur = mq[0];
                check("b_data", b_mdata, cur[mchan*16 +: 16]);
                check("b_chan", b_chan, mchan);
                check("b_first", b_first, mchan == 0);
                check("b_last", b_last, mchan == 3);
            end
            check("b_overflow", b_ovf, movf);
            check("b_frame_cnt", b_fc, mfc);
        end
    end

    logic [15:0] rec[$];
    logic        v_arr[10];
    logic [15:0] d_arr[10];
    logic [63:0] lit4;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_first", a_first, 0);
        check("rst_a_last", a_last, 0);
        check("rst_a_chan", a_chan, 0);
        check("rst_a_data", a_mdata, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_a_fc", a_fc, 0);
        check("rst_c_valid", c_valid, 0);
        @(posedge clk);
        #1;
        rst = 0;
        cmp_en = 1;

        // 20-channel frame with m_ready held high
        for (int k = 0; k < 20; k++) a_data[k*16 +: 16] = 16'h0100 + 16'(k);
        a_stb = 1;
        tick();
        a_stb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("a_valid", a_valid, 1);
            check("a_data", a_mdata, 16'h0100 + 16'(k));
            check("a_chan", a_chan, k);
            check("a_first", a_first, k == 0);
            check("a_last", a_last, k == 19);
            @(posedge clk);
        end
        @(negedge clk);
        check("a_valid_end", a_valid, 0);
        check("a_fc_end", a_fc, 1);

        // Bit-exact extreme values under a toggling m_ready
        tick();
        lit4 = {16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
        b_data = lit4;
        b_stb = 1;
        tick();
        b_stb = 0;
        for (int i = 0; i < 20 && rec.size() < 4; i++) begin
            b_ready = (i % 2 == 0);
            @(negedge clk);
            if (b_valid && b_ready) rec.push_back(b_mdata);
            tick();
        end
        check("toggle_count", rec.size(), 4);
        if (rec.size() == 4) begin
            check("toggle_d0", rec[0], 16'h8000);
            check("toggle_d1", rec[1], 16'h7FFF);
            check("toggle_d2", rec[2], 16'hFFFF);
            check("toggle_d3", rec[3], 16'h0001);
        end
        b_ready = 0;
        repeat (3) tick();

        // Stalled sink: third strobe is dropped, coincident clear loses to the set
        b_stb = 1;
        b_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        tick();
        b_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        tick();
        b_data = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        b_clr = 1;
        tick();
        b_stb = 0;
        b_clr = 0;
        b_ready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v_arr[i] = b_valid;
            d_arr[i] = b_mdata;
            if (i == 0) check("drop_ovf", b_ovf, 1);
            if (i == 9) check("drop_fc", b_fc, 3);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check("b2b_valid", v_arr[i], i < 8);
            if (i < 8) check("b2b_data", d_arr[i], (i < 4) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i - 4));
        end

        // Strobe on the completing handshake with pending empty
        b_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        b_stb = 1;
        tick();
        b_stb = 0;
        repeat (3) tick();
        b_data = {16'hE003, 16'hE002, 16'hE001, 16'hE000};
        b_stb = 1;
        @(negedge clk);
        check("coinc_pre_chan", b_chan, 3);
        tick();
        b_stb = 0;
        @(negedge clk);
        check("coinc_valid", b_valid, 1);
        check("coinc_first", b_first, 1);
        check("coinc_data", b_mdata, 16'hE000);
        tick();
        repeat (6) tick();

        // Randomized traffic against the frame-FIFO reference
        for (int i = 0; i < 1500; i++) begin
            b_stb   = ($urandom_range(0, 7) == 0);
            b_ready = ($urandom_range(0, 9) < 7);
            b_clr   = ($urandom_range(0, 15) == 0);
            b_data  = {$urandom, $urandom};
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        b_stb = 0;
        b_clr = 0;
        rst = 0;

        // Reset in the middle of a frame
        b_ready = 1;
        rst = 1;
        tick();
        rst = 0;
        b_data = {16'h1103, 16'h1102, 16'h1101, 16'h1100};
        b_stb = 1;
        tick();
        b_stb = 0;
        tick();
        tick();
        rst = 1;
        @(negedge clk);
        check("midrst_pre_chan", b_chan, 2);
        tick();
        rst = 0;
        @(negedge clk);
        check("midrst_valid", b_valid, 0);
        check("midrst_fc", b_fc, 0);
        check("midrst_ovf", b_ovf, 0);
        b_data = {16'h2203, 16'h2202, 16'h2201, 16'h2200};
        b_stb = 1;
        tick();
        b_stb = 0;
        @(negedge clk);
        check("midrst_chan", b_chan, 0);
        check("midrst_first", b_first, 1);
        check("midrst_data", b_mdata, 16'h2200);
        tick();

        // frame_cnt wrap with one-channel frames completing every cycle
        c_ready = 1;
        c_data = 16'hABCD;
        c_stb = 1;
        repeat (65536) tick();
        @(negedge clk);
        check("wrap_pre_fc", c_fc, 16'hFFFF);
        check("wrap_data", c_mdata, 16'hABCD);
        check("wrap_first", c_first, 1);
        check("wrap_last", c_last, 1);
        tick();
        @(negedge clk);
        check("wrap_fc", c_fc, 0);
        c_stb = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
